// File: rtl/ha_array_mul_arbiter_if.sv
// Bundle between the requesters, the shared partial-product stage and the
// result consumer. "master" is the arbiter's view; "slave" is the environment's.
interface ha_array_mul_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_x;
  logic [7:0] req0_y;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_x;
  logic [7:0] req1_y;

  logic [7:0] mul_x;
  logic [7:0] mul_y;

  logic [6:0] ha_array_0_b;
  logic [8:0] ha_array_0_t;
  logic [6:0] ha_array_1_b;
  logic [8:0] ha_array_1_t;
  logic [6:0] ha_array_2_b;
  logic [8:0] ha_array_2_t;
  logic [6:0] ha_array_3_b;
  logic [8:0] ha_array_3_t;

  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_id;

  modport master (
    input  req0_valid, req0_x, req0_y,
    input  req1_valid, req1_x, req1_y,
    output req0_ready, req1_ready,
    output mul_x, mul_y,
    input  ha_array_0_b, ha_array_0_t, ha_array_1_b, ha_array_1_t,
    input  ha_array_2_b, ha_array_2_t, ha_array_3_b, ha_array_3_t,
    output res_valid, res_data, res_id,
    input  res_ready
  );

  modport slave (
    output req0_valid, req0_x, req0_y,
    output req1_valid, req1_x, req1_y,
    input  req0_ready, req1_ready,
    input  mul_x, mul_y,
    output ha_array_0_b, ha_array_0_t, ha_array_1_b, ha_array_1_t,
    output ha_array_2_b, ha_array_2_t, ha_array_3_b, ha_array_3_t,
    input  res_valid, res_data, res_id,
    output res_ready
  );
endinterface

// File: rtl/ha_array_mul_arbiter.sv
// Round-robin arbiter and reduction sequencer for the shared approximate 8x8
// partial-product stage; folds four half-adder arrays into a saturated product.
module ha_array_mul_arbiter #(
  parameter int ARRAYS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ha_array_mul_arbiter_if.master bus
);

  localparam int DATA_W = 8;
  localparam int ACC_W  = 17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RED  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [1:0]          idx_q, idx_d;
  logic                id_q, id_d;

  logic                gnt0, gnt1;
  logic                idle_open;
  logic                accept;
  logic                last_red;
  logic [ACC_W-1:0]    term [4];
  logic [ACC_W-1:0]    red_sum;

  // Weighted value of one row-pair array: sum row plus carry row (two columns up),
  // then placed at the array's row offset 2k.
  function automatic logic [ACC_W-1:0] array_term(input logic [8:0] t,
                                                  input logic [6:0] b,
                                                  input int         k);
    logic [9:0] base;
    base = {1'b0, t} + {1'b0, b, 2'b00};
    return ACC_W'(base) << (2 * k);
  endfunction

  // The approximate arrays can overshoot 16 bits; clamp rather than wrap.
  function automatic logic [15:0] sat16(input logic [ACC_W-1:0] a);
    return a[16] ? 16'hFFFF : a[15:0];
  endfunction

  always_comb begin
    term[0] = array_term(bus.ha_array_0_t, bus.ha_array_0_b, 0);
    term[1] = array_term(bus.ha_array_1_t, bus.ha_array_1_b, 1);
    term[2] = array_term(bus.ha_array_2_t, bus.ha_array_2_b, 2);
    term[3] = array_term(bus.ha_array_3_t, bus.ha_array_3_b, 3);
  end

  always_comb begin
    red_sum = '0;
    for (int i = 0; i < ARRAYS_PER_CYCLE; i++) begin
      red_sum = red_sum + term[idx_q + 2'(i)];
    end
  end

  assign last_red = ((idx_q + 2'(ARRAYS_PER_CYCLE - 1)) == 2'd3);

  // Pointer only breaks ties; a lone requester always wins.
  assign gnt0      = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
  assign gnt1      = bus.req1_valid & (~bus.req0_valid |  ptr_q);
  assign idle_open = (state_q == S_IDLE) & ~rst;
  assign accept    = idle_open & (gnt0 | gnt1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d     = gnt1 ? bus.req1_x : bus.req0_x;
          y_d     = gnt1 ? bus.req1_y : bus.req0_y;
          id_d    = gnt1;
          ptr_d   = ~gnt1;
          acc_d   = '0;
          idx_d   = 2'd0;
          state_d = S_RED;
        end
      end
      S_RED: begin
        acc_d = acc_q + red_sum;
        idx_d = idx_q + 2'(ARRAYS_PER_CYCLE);
        if (last_red) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      idx_q   <= 2'd0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
    end
  end

  assign bus.req0_ready = idle_open & gnt0;
  assign bus.req1_ready = idle_open & gnt1;
  assign bus.mul_x      = x_q;
  assign bus.mul_y      = y_q;
  assign bus.res_valid  = (state_q == S_DONE);
  assign bus.res_data   = sat16(acc_q);
  assign bus.res_id     = id_q;

endmodule

// File: tb/tb_ha_array_mul_arbiter.sv
// Directed bench: three arbiters (1, 2 and 4 arrays per cycle) share one set of
// requesters; a table-driven stage stub supplies the ha_array rows.
module tb_ha_array_mul_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0v, r1v, rrdy, sat;
  logic [7:0] r0x, r0y, r1x, r1y;

  logic        rdy0 [3];
  logic        rdy1 [3];
  logic        rv   [3];
  logic        rid  [3];
  logic [15:0] rd   [3];
  logic [7:0]  mx   [3];
  logic [7:0]  my   [3];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Stage stub: returns {b[6:0], t[8:0]} of array k for a few operand pairs.
  function automatic logic [15:0] stub(input logic [7:0] x, input logic [7:0] y,
                                       input int k, input logic s);
    logic [8:0] t [4];
    logic [6:0] b [4];
    for (int i = 0; i < 4; i++) begin
      t[i] = '0;
      b[i] = '0;
    end
    if (s) return 16'hFFFF;
    case ({x, y})
      16'h0101: t[0] = 9'd1;
      16'h0203: t[0] = 9'd2;
      16'h0104: t[1] = 9'd2;
      16'h0305: begin
        t[0] = 9'd1; b[0] = 7'd1; t[1] = 9'd3; t[2] = 9'd1; b[3] = 7'd1;
      end
      default: ;
    endcase
    return {b[k], t[k]};
  endfunction

  ha_array_mul_arbiter_if bi [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_inst
    assign bi[g].req0_valid = r0v;
    assign bi[g].req0_x     = r0x;
    assign bi[g].req0_y     = r0y;
    assign bi[g].req1_valid = r1v;
    assign bi[g].req1_x     = r1x;
    assign bi[g].req1_y     = r1y;
    assign bi[g].res_ready  = rrdy;
    assign {bi[g].ha_array_0_b, bi[g].ha_array_0_t} = stub(bi[g].mul_x, bi[g].mul_y, 0, sat);
    assign {bi[g].ha_array_1_b, bi[g].ha_array_1_t} = stub(bi[g].mul_x, bi[g].mul_y, 1, sat);
    assign {bi[g].ha_array_2_b, bi[g].ha_array_2_t} = stub(bi[g].mul_x, bi[g].mul_y, 2, sat);
    assign {bi[g].ha_array_3_b, bi[g].ha_array_3_t} = stub(bi[g].mul_x, bi[g].mul_y, 3, sat);
    assign rdy0[g] = bi[g].req0_ready;
    assign rdy1[g] = bi[g].req1_ready;
    assign rv[g]   = bi[g].res_valid;
    assign rid[g]  = bi[g].res_id;
    assign rd[g]   = bi[g].res_data;
    assign mx[g]   = bi[g].mul_x;
    assign my[g]   = bi[g].mul_y;

    ha_array_mul_arbiter #(.ARRAYS_PER_CYCLE(1 << g)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bi[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accept edge; expects latency 4/2/1 for instances 0/1/2.
  task automatic wait_res(input logic [15:0] ed, input logic eid);
    int          lat [3];
    logic [15:0] dat [3];
    logic        idv [3];
    for (int g = 0; g < 3; g++) begin
      lat[g] = 0; dat[g] = '0; idv[g] = 1'b0;
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        if (rv[g] && lat[g] == 0) begin
          lat[g] = c; dat[g] = rd[g]; idv[g] = rid[g];
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      check($sformatf("latency_apc%0d", 1 << g), 32'(lat[g]), 32'(4 >> g));
      check($sformatf("data_apc%0d", 1 << g), 32'(dat[g]), 32'(ed));
      check($sformatf("id_apc%0d", 1 << g), 32'(idv[g]), 32'(eid));
    end
  endtask

  task automatic do_xact(input logic [7:0] x, input logic [7:0] y, input logic [15:0] ed);
    r0x = x; r0y = y; r0v = 1'b1; r1v = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) check("xact_ready0", 32'(rdy0[g]), 32'd1);
    tick();
    r0v = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check("xact_mul_x", 32'(mx[g]), 32'(x));
      check("xact_mul_y", 32'(my[g]), 32'(y));
    end
    wait_res(ed, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1; sat = 1'b0; rrdy = 1'b1;
    r0v = 1'b1; r1v = 1'b1;
    r0x = 8'd1; r0y = 8'd1; r1x = 8'd2; r1y = 8'd3;
    repeat (2) tick();
    for (int g = 0; g < 3; g++) begin
      check("rst_ready0", 32'(rdy0[g]), 32'd0);
      check("rst_ready1", 32'(rdy1[g]), 32'd0);
      check("rst_valid", 32'(rv[g]), 32'd0);
      check("rst_data", 32'(rd[g]), 32'd0);
      check("rst_id", 32'(rid[g]), 32'd0);
      check("rst_mul_x", 32'(mx[g]), 32'd0);
      check("rst_mul_y", 32'(my[g]), 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check("first_ready0", 32'(rdy0[g]), 32'd1);
      check("first_ready1", 32'(rdy1[g]), 32'd0);
    end
    tick();
    r0v = 1'b0; r1v = 1'b0;
    for (int g = 0; g < 3; g++) check("first_mul_x", 32'(mx[g]), 32'd1);
    wait_res(16'd1, 1'b0);

    do_xact(8'd2, 8'd3, 16'd2);
    do_xact(8'd1, 8'd4, 16'd8);
    do_xact(8'd0, 8'hFF, 16'd0);
    do_xact(8'd3, 8'd5, 16'd289);

    // Round robin from a fresh pointer with both requesters held valid.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r0x = 8'd1; r0y = 8'd4; r1x = 8'd2; r1y = 8'd3;
    r0v = 1'b1; r1v = 1'b1; rrdy = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      tick();
      check("rr_ready_excl", 32'(rdy0[0] & rdy1[0]), 32'd0);
      if (rv[0]) begin
        check("rr_id", 32'(rid[0]), 32'(n % 2));
        check("rr_data", 32'(rd[0]), (n % 2) ? 32'd2 : 32'd8);
        check("rr_mul_x", 32'(mx[0]), (n % 2) ? 32'd2 : 32'd1);
        n++;
      end
    end
    check("rr_count", 32'(n), 32'd6);
    r0v = 1'b0; r1v = 1'b0;
    repeat (8) tick();

    // Back-pressure in DONE with both requesters tempting a second accept.
    r0x = 8'd3; r0y = 8'd5; r0v = 1'b1; r1v = 1'b0; rrdy = 1'b0;
    tick();
    r1v = 1'b1;
    for (int c = 0; c < 10 && !rv[0]; c++) tick();
    check("bp_reached_done", 32'(rv[0]), 32'd1);
    for (int c = 0; c < 10; c++) begin
      for (int g = 0; g < 3; g++) begin
        check("bp_valid", 32'(rv[g]), 32'd1);
        check("bp_data", 32'(rd[g]), 32'd289);
      end
      check("bp_ready0", 32'(rdy0[0]), 32'd0);
      check("bp_ready1", 32'(rdy1[0]), 32'd0);
      check("bp_mul_x", 32'(mx[0]), 32'd3);
      tick();
    end
    rrdy = 1'b1;
    tick();
    check("rel_valid", 32'(rv[0]), 32'd0);
    check("rel_ready1", 32'(rdy1[0]), 32'd1);
    check("rel_ready0", 32'(rdy0[0]), 32'd0);
    r0v = 1'b0; r1v = 1'b0;
    repeat (2) tick();

    sat = 1'b1;
    do_xact(8'h55, 8'hAA, 16'hFFFF);
    sat = 1'b0;

    // Reset during the second reduction cycle.
    r0x = 8'd1; r0y = 8'd4; r0v = 1'b1; r1v = 1'b0;
    tick();
    r0v = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      check("mr_valid", 32'(rv[g]), 32'd0);
      check("mr_mul_x", 32'(mx[g]), 32'd0);
      check("mr_mul_y", 32'(my[g]), 32'd0);
      check("mr_data", 32'(rd[g]), 32'd0);
      check("mr_ready0", 32'(rdy0[g]), 32'd0);
    end
    tick();
    r0x = 8'd2; r0y = 8'd3; r1x = 8'd1; r1y = 8'd4;
    r0v = 1'b1; r1v = 1'b1; rst = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check("mr_next_ready0", 32'(rdy0[g]), 32'd1);
      check("mr_next_ready1", 32'(rdy1[g]), 32'd0);
    end
    tick();
    r0v = 1'b0; r1v = 1'b0;
    wait_res(16'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
